// File: rtl/clock_core.sv
// clock_core: BCD mm:ss timekeeping core.
// Prescaled 1 s advance, freeze in set mode, commit on set-mode release.
module clock_core #(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 26
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       set_mode,
  input  logic       run,
  input  logic [3:0] set_min10,
  input  logic [3:0] set_min01,
  input  logic [3:0] set_sec10,
  input  logic [3:0] set_sec01,
  output logic [3:0] cur_min10,
  output logic [3:0] cur_min01,
  output logic [3:0] cur_sec10,
  output logic [3:0] cur_sec01,
  output logic       tick_1s,
  output logic       rollover,
  output logic       committed
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] pre;
  logic             set_mode_d;
  logic             commit;
  logic             adv;
  logic             cnt_en;
  logic             at_tc;
  logic             wrap;
  logic [3:0]       m10_n;
  logic [3:0]       m01_n;
  logic [3:0]       s10_n;
  logic [3:0]       s01_n;
  logic [3:0]       g_m10;
  logic [3:0]       g_m01;
  logic [3:0]       g_s10;
  logic [3:0]       g_s01;

  // Decode the mutually exclusive actions for this cycle.
  always_comb begin
    at_tc  = (pre == TC);
    commit = set_mode_d & ~set_mode;
    adv    = ~commit & ~set_mode & run & at_tc;
    cnt_en = ~commit & ~set_mode & run & ~at_tc;
  end

  // Out-of-range edited digits load as zero.
  always_comb begin
    g_m10 = (set_min10 > 4'd5) ? 4'd0 : set_min10;
    g_m01 = (set_min01 > 4'd9) ? 4'd0 : set_min01;
    g_s10 = (set_sec10 > 4'd5) ? 4'd0 : set_sec10;
    g_s01 = (set_sec01 > 4'd9) ? 4'd0 : set_sec01;
  end

  // One-second increment with the BCD carry chain.
  always_comb begin
    m10_n = cur_min10;
    m01_n = cur_min01;
    s10_n = cur_sec10;
    s01_n = cur_sec01;
    wrap  = 1'b0;
    if (cur_sec01 != 4'd9) begin
      s01_n = cur_sec01 + 4'd1;
    end else begin
      s01_n = 4'd0;
      if (cur_sec10 != 4'd5) begin
        s10_n = cur_sec10 + 4'd1;
      end else begin
        s10_n = 4'd0;
        if (cur_min01 != 4'd9) begin
          m01_n = cur_min01 + 4'd1;
        end else begin
          m01_n = 4'd0;
          if (cur_min10 != 4'd5) begin
            m10_n = cur_min10 + 4'd1;
          end else begin
            m10_n = 4'd0;
            wrap  = 1'b1;
          end
        end
      end
    end
  end

  // State: prescaler, digits, pulses and the set_mode delay.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      pre        <= '0;
      set_mode_d <= 1'b0;
      cur_min10  <= 4'd0;
      cur_min01  <= 4'd0;
      cur_sec10  <= 4'd0;
      cur_sec01  <= 4'd0;
      tick_1s    <= 1'b0;
      rollover   <= 1'b0;
      committed  <= 1'b0;
    end else begin
      set_mode_d <= set_mode;
      tick_1s    <= 1'b0;
      rollover   <= 1'b0;
      committed  <= 1'b0;
      unique case (1'b1)
        commit: begin
          pre       <= '0;
          cur_min10 <= g_m10;
          cur_min01 <= g_m01;
          cur_sec10 <= g_s10;
          cur_sec01 <= g_s01;
          committed <= 1'b1;
        end
        set_mode: begin
          pre <= '0;
        end
        adv: begin
          pre       <= '0;
          cur_min10 <= m10_n;
          cur_min01 <= m01_n;
          cur_sec10 <= s10_n;
          cur_sec01 <= s01_n;
          tick_1s   <= 1'b1;
          rollover  <= wrap;
        end
        cnt_en: begin
          pre <= pre + CNT_W'(1);
        end
        default: begin
          pre <= pre;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_core.sv
// tb_clock_core: scoreboard bench for clock_core.
// Model tracks elapsed seconds as an integer, not BCD digits.
module tb_clock_core;

  localparam int HZ = 4;

  typedef struct packed {
    logic [15:0] cur;
    logic        tick;
    logic        roll;
    logic        com;
  } exp_t;

  logic       MCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       set_mode = 1'b0;
  logic       run = 1'b0;
  logic [3:0] set_min10 = 4'd0;
  logic [3:0] set_min01 = 4'd0;
  logic [3:0] set_sec10 = 4'd0;
  logic [3:0] set_sec01 = 4'd0;
  logic [3:0] cur_min10;
  logic [3:0] cur_min01;
  logic [3:0] cur_sec10;
  logic [3:0] cur_sec01;
  logic       tick_1s;
  logic       rollover;
  logic       committed;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  int secs = 0;
  int pre  = 0;
  bit smd  = 1'b0;

  clock_core #(.CLK_HZ(HZ), .CNT_W(3)) dut (
    .MCLK(MCLK),
    .RESET(RESET),
    .set_mode(set_mode),
    .run(run),
    .set_min10(set_min10),
    .set_min01(set_min01),
    .set_sec10(set_sec10),
    .set_sec01(set_sec01),
    .cur_min10(cur_min10),
    .cur_min01(cur_min01),
    .cur_sec10(cur_sec10),
    .cur_sec01(cur_sec01),
    .tick_1s(tick_1s),
    .rollover(rollover),
    .committed(committed)
  );

  always #5 MCLK = ~MCLK;

  function automatic logic [15:0] cur_now();
    return {cur_min10, cur_min01, cur_sec10, cur_sec01};
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    a = 4'(s / 600);
    b = 4'((s / 60) % 10);
    c = 4'((s % 60) / 10);
    d = 4'(s % 10);
    return {a, b, c, d};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the model's response.
  task automatic step(input bit sm, input bit rn, input int a,
                      input int b, input int c, input int d);
    exp_t e;
    @(negedge MCLK);
    set_mode  = sm;
    run       = rn;
    set_min10 = 4'(a);
    set_min01 = 4'(b);
    set_sec10 = 4'(c);
    set_sec01 = 4'(d);
    e = '0;
    if (smd && !sm) begin
      secs = ((a > 5) ? 0 : a) * 600 + ((b > 9) ? 0 : b) * 60
           + ((c > 5) ? 0 : c) * 10 + ((d > 9) ? 0 : d);
      pre   = 0;
      e.com = 1'b1;
    end else if (sm) begin
      pre = 0;
    end else if (rn) begin
      if (pre == HZ - 1) begin
        pre    = 0;
        secs   = (secs + 1) % 3600;
        e.tick = 1'b1;
        e.roll = (secs == 0);
      end else begin
        pre++;
      end
    end
    smd   = sm;
    e.cur = to_bcd(secs);
    q.push_back(e);
  endtask

  task automatic runs(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
  endtask

  task automatic post();
    @(posedge MCLK);
    #2;
  endtask

  // Monitor: compare every registered output against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge MCLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_cur", cur_now(), e.cur);
        chk("sb_pulses", {13'd0, tick_1s, rollover, committed},
            {13'd0, e.tick, e.roll, e.com});
      end
    end
  end

  initial begin
    bit sm;
    bit rn;
    #12;
    chk("reset_cur", cur_now(), 16'h0000);
    chk("reset_pulses", {13'd0, tick_1s, rollover, committed}, 16'h0000);
    @(negedge MCLK);
    RESET = 1'b0;

    runs(40);
    post();
    chk("count_40", cur_now(), 16'h0010);

    step(1, 1, 5, 9, 5, 9);
    step(0, 1, 5, 9, 5, 9);
    post();
    chk("commit_5959", cur_now(), 16'h5959);
    runs(4);
    post();
    chk("wrap_cur", cur_now(), 16'h0000);
    chk("wrap_pulses", {14'd0, tick_1s, rollover}, 16'h0003);
    runs(1);
    post();
    chk("wrap_after", {14'd0, tick_1s, rollover}, 16'h0000);

    for (int i = 0; i < 20; i++) step(1, 1, 1, 2, 3, 4);
    post();
    chk("freeze_cur", cur_now(), 16'h0000);
    step(0, 1, 1, 2, 3, 4);
    post();
    chk("commit_1234", {cur_now()}, 16'h1234);
    chk("commit_pulse", {15'd0, committed}, 16'h0001);
    runs(4);
    post();
    chk("tick_1235", {cur_now()}, 16'h1235);

    step(1, 1, 7, 3, 6, 10);
    step(0, 1, 7, 3, 6, 10);
    post();
    chk("guard_0300", cur_now(), 16'h0300);

    runs(3);
    step(1, 1, 2, 2, 2, 2);
    step(0, 1, 2, 2, 2, 2);
    post();
    chk("tc_commit_cur", cur_now(), 16'h2222);
    chk("tc_no_tick", {15'd0, tick_1s}, 16'h0000);

    runs(2);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
    runs(1);
    post();
    chk("pause_no_tick", {15'd0, tick_1s}, 16'h0000);
    runs(1);
    post();
    chk("pause_tick", {cur_now()}, 16'h2223);

    #1;
    RESET = 1'b1;
    #1;
    chk("async_cur", cur_now(), 16'h0000);
    chk("async_pulses", {13'd0, tick_1s, rollover, committed}, 16'h0000);
    run = 1'b0;
    set_mode = 1'b0;
    secs = 0;
    pre = 0;
    smd = 1'b0;
    @(negedge MCLK);
    RESET = 1'b0;

    sm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) sm = ~sm;
      rn = ($urandom_range(0, 7) != 0);
      step(sm, rn, $urandom_range(0, 7), $urandom_range(0, 11),
           $urandom_range(0, 7), $urandom_range(0, 11));
    end

    post();
    post();
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
